sprite_motion_ctl: RTL and testbench

- Frame-rate motion controller that generates the xpos/ypos (and animation frame select) consumed by the rectangle/sprite draw stage directly downstream.
- Marches one sprite (or a formation anchor) horizontally across the screen in discrete steps, once every FRAME_DIV frames.
- On reaching a horizontal limit it drops by STEP_Y and reverses direction. On reaching the bottom limit it stops and flags landed.
- Updates occur only at vertical-blank start, so the draw stage never sees a position change mid-frame.

---
 rtl/sprite_motion_ctl.sv | 163 ++++++++++++++++
 tb/tb_sprite_motion_ctl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctl.sv
// Frame-rate sprite march controller: steps horizontally every FRAME_DIV frames,
// drops and reverses at the side limits, and stops once it reaches the bottom limit.
module sprite_motion_ctl #(
    parameter int unsigned RECT_WIDTH  = 32,
    parameter int unsigned RECT_HEIGHT = 32,
    parameter int unsigned X_START     = 64,
    parameter int unsigned Y_START     = 64,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 1024,
    parameter int unsigned Y_MAX       = 768,
    parameter int unsigned STEP_X      = 8,
    parameter int unsigned STEP_Y      = 16,
    parameter int unsigned FRAME_DIV   = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        restart,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        anim_frame,
    output logic        dir_left,
    output logic        landed,
    output logic        step_strobe
);

    if (X_START + RECT_WIDTH > X_MAX || X_START < X_MIN || Y_START + RECT_HEIGHT > Y_MAX
        || FRAME_DIV < 1) begin : g_bad_params
        $fatal(1, "sprite_motion_ctl: illegal start position or FRAME_DIV");
    end

    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    localparam logic [12:0] SX13   = 13'(STEP_X);
    localparam logic [12:0] SY13   = 13'(STEP_Y);
    localparam logic [12:0] RW13   = 13'(RECT_WIDTH);
    localparam logic [12:0] RH13   = 13'(RECT_HEIGHT);
    localparam logic [12:0] XMIN13 = 13'(X_MIN);
    localparam logic [12:0] XMAX13 = 13'(X_MAX);
    localparam logic [12:0] YMAX13 = 13'(Y_MAX);
    localparam logic [11:0] SX12   = 12'(STEP_X);
    localparam logic [11:0] SY12   = 12'(STEP_Y);
    localparam logic [11:0] XST12  = 12'(X_START);
    localparam logic [11:0] YST12  = 12'(Y_START);
    localparam logic [11:0] YLAND  = 12'(Y_MAX - RECT_HEIGHT);

    typedef enum logic [1:0] {StMoveR, StMoveL, StLanded} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vblnk_q, tick_q, tick_d;
    logic [11:0]   xpos_q, xpos_d, ypos_q, ypos_d;
    logic          anim_q, anim_d, dir_q, dir_d, landed_q, landed_d, strobe_q, strobe_d;
    logic          advance, step, descend;
    logic [12:0]   x13, y13;

    assign x13 = {1'b0, xpos_q};
    assign y13 = {1'b0, ypos_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        anim_d   = anim_q;
        dir_d    = dir_q;
        landed_d = landed_q;
        strobe_d = 1'b0;
        descend  = 1'b0;
        // Registered edge detect gives the two-clock vblnk-to-output latency.
        tick_d   = vblnk & ~vblnk_q;
        advance  = tick_q & enable & (state_q != StLanded);
        step     = advance & (cnt_q == CNT_LAST);

        if (advance) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end

        if (step) begin
            strobe_d = 1'b1;
            anim_d   = ~anim_q;
            case (state_q)
                StMoveR: begin
                    if (x13 + SX13 + RW13 <= XMAX13) begin
                        xpos_d = xpos_q + SX12;
                    end else begin
                        descend = 1'b1;
                        state_d = StMoveL;
                        dir_d   = 1'b1;
                    end
                end
                StMoveL: begin
                    if (x13 >= XMIN13 + SX13) begin
                        xpos_d = xpos_q - SX12;
                    end else begin
                        descend = 1'b1;
                        state_d = StMoveR;
                        dir_d   = 1'b0;
                    end
                end
                default: ;
            endcase
            if (descend) begin
                if (y13 + SY13 + RH13 < YMAX13) begin
                    ypos_d = ypos_q + SY12;
                end else begin
                    ypos_d   = YLAND;
                    state_d  = StLanded;
                    landed_d = 1'b1;
                end
            end
        end

        // vblnk_q keeps sampling through restart so a high vblnk cannot fake an edge.
        if (restart) begin
            state_d  = StMoveR;
            cnt_d    = '0;
            xpos_d   = XST12;
            ypos_d   = YST12;
            anim_d   = 1'b0;
            dir_d    = 1'b0;
            landed_d = 1'b0;
            strobe_d = 1'b0;
            tick_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StMoveR;
            cnt_q    <= '0;
            vblnk_q  <= 1'b0;
            tick_q   <= 1'b0;
            xpos_q   <= XST12;
            ypos_q   <= YST12;
            anim_q   <= 1'b0;
            dir_q    <= 1'b0;
            landed_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vblnk_q  <= vblnk;
            tick_q   <= tick_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            anim_q   <= anim_d;
            dir_q    <= dir_d;
            landed_q <= landed_d;
            strobe_q <= strobe_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign anim_frame  = anim_q;
    assign dir_left    = dir_q;
    assign landed      = landed_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_sprite_motion_ctl.sv
// Directed bench for sprite_motion_ctl: four instances with different parameter sets,
// each driven by its own vblnk/enable/restart.
module tb_sprite_motion_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  vb, en, rs;
    logic [11:0] xp [4];
    logic [11:0] yp [4];
    logic [3:0]  an, dl, ld, st;
    logic [3:0]  s_at1, s_at2, s_at3;
    int          sc [4];
    int          snap;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sprite_motion_ctl #(.FRAME_DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .restart(rs[0]), .vblnk(vb[0]),
        .xpos(xp[0]), .ypos(yp[0]), .anim_frame(an[0]), .dir_left(dl[0]),
        .landed(ld[0]), .step_strobe(st[0])
    );

    sprite_motion_ctl #(.X_START(976), .FRAME_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .restart(rs[1]), .vblnk(vb[1]),
        .xpos(xp[1]), .ypos(yp[1]), .anim_frame(an[1]), .dir_left(dl[1]),
        .landed(ld[1]), .step_strobe(st[1])
    );

    sprite_motion_ctl #(.X_START(12), .X_MAX(52), .FRAME_DIV(1)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .restart(rs[2]), .vblnk(vb[2]),
        .xpos(xp[2]), .ypos(yp[2]), .anim_frame(an[2]), .dir_left(dl[2]),
        .landed(ld[2]), .step_strobe(st[2])
    );

    sprite_motion_ctl #(.X_START(992), .Y_START(720), .FRAME_DIV(1)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(en[3]), .restart(rs[3]), .vblnk(vb[3]),
        .xpos(xp[3]), .ypos(yp[3]), .anim_frame(an[3]), .dir_left(dl[3]),
        .landed(ld[3]), .step_strobe(st[3])
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (st[i] === 1'b1) sc[i] <= sc[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One vblnk pulse on instance i; strobes sampled 1, 2 and 3 clocks after the rise.
    task automatic pulse(input int i);
        vb[i] = 1'b1;
        @(negedge clk); s_at1 = st;
        @(negedge clk); s_at2 = st;
        vb[i] = 1'b0;
        @(negedge clk); s_at3 = st;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        vb = '0;
        en = 4'hf;
        rs = '0;
        repeat (3) @(negedge clk);
        chk("rst_xpos", 32'(xp[0]), 64);
        chk("rst_ypos", 32'(yp[0]), 64);
        chk("rst_anim", 32'(an[0]), 0);
        chk("rst_dir", 32'(dl[0]), 0);
        chk("rst_landed", 32'(ld[0]), 0);
        chk("rst_strobe", 32'(st[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // u0, FRAME_DIV=2: step only on the 2nd pulse
        pulse(0);
        chk("div_p1_strobe", 32'(s_at2[0]), 0);
        chk("div_p1_xpos", 32'(xp[0]), 64);
        pulse(0);
        chk("div_p2_strobe_early", 32'(s_at1[0]), 0);
        chk("div_p2_strobe", 32'(s_at2[0]), 1);
        chk("div_p2_strobe_late", 32'(s_at3[0]), 0);
        chk("div_p2_xpos", 32'(xp[0]), 72);
        chk("div_p2_anim", 32'(an[0]), 1);
        chk("div_p2_ypos", 32'(yp[0]), 64);
        pulse(0);
        chk("div_p3_xpos", 32'(xp[0]), 72);

        // vblnk held high: exactly one tick
        snap = sc[0];
        vb[0] = 1'b1;
        repeat (500) @(negedge clk);
        vb[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_strobes", 32'(sc[0] - snap), 1);
        chk("held_xpos", 32'(xp[0]), 80);
        pulse(0);
        chk("held_next_xpos", 32'(xp[0]), 80);

        // enable=0 across 5 pulses freezes counter and outputs
        en[0] = 1'b0;
        snap = sc[0];
        for (int k = 0; k < 5; k++) pulse(0);
        chk("dis_strobes", 32'(sc[0] - snap), 0);
        chk("dis_xpos", 32'(xp[0]), 80);
        chk("dis_anim", 32'(an[0]), 0);
        en[0] = 1'b1;
        pulse(0);
        chk("reen_xpos", 32'(xp[0]), 88);
        chk("reen_anim", 32'(an[0]), 1);

        // re-enabling while vblnk is high must not create a tick
        en[0] = 1'b0;
        snap = sc[0];
        vb[0] = 1'b1;
        repeat (3) @(negedge clk);
        en[0] = 1'b1;
        repeat (5) @(negedge clk);
        vb[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("reen_high_strobes", 32'(sc[0] - snap), 0);
        pulse(0);
        chk("reen_high_next_xpos", 32'(xp[0]), 88);

        // u1: right bound, descent, reverse
        pulse(1);
        chk("rb_t1_xpos", 32'(xp[1]), 984);
        pulse(1);
        chk("rb_t2_xpos", 32'(xp[1]), 992);
        pulse(1);
        chk("rb_t3_xpos", 32'(xp[1]), 992);
        chk("rb_t3_ypos", 32'(yp[1]), 80);
        chk("rb_t3_dir", 32'(dl[1]), 1);
        chk("rb_t3_strobe", 32'(s_at2[1]), 1);
        pulse(1);
        chk("rb_t4_xpos", 32'(xp[1]), 984);
        pulse(1);
        chk("rb_t5_xpos", 32'(xp[1]), 976);

        // restart coincident with a step tick (tick_q high in the cycle restart is held)
        snap = sc[1];
        vb[1] = 1'b1;
        @(negedge clk);
        rs[1] = 1'b1;
        @(negedge clk);
        rs[1] = 1'b0;
        chk("rst_pulse_xpos", 32'(xp[1]), 976);
        chk("rst_pulse_ypos", 32'(yp[1]), 64);
        chk("rst_pulse_dir", 32'(dl[1]), 0);
        chk("rst_pulse_anim", 32'(an[1]), 0);
        chk("rst_pulse_strobe", 32'(st[1]), 0);
        repeat (3) @(negedge clk);
        vb[1] = 1'b0;
        @(negedge clk);
        chk("rst_pulse_no_step", 32'(sc[1] - snap), 0);
        pulse(1);
        chk("rst_pulse_then_step", 32'(xp[1]), 984);

        // u2: left bound descends instead of moving
        pulse(2);
        chk("lb_t1_xpos", 32'(xp[2]), 20);
        pulse(2);
        chk("lb_t2_dir", 32'(dl[2]), 1);
        chk("lb_t2_ypos", 32'(yp[2]), 80);
        pulse(2);
        chk("lb_t3_xpos", 32'(xp[2]), 12);
        pulse(2);
        chk("lb_t4_xpos", 32'(xp[2]), 4);
        pulse(2);
        chk("lb_t5_xpos", 32'(xp[2]), 4);
        chk("lb_t5_dir", 32'(dl[2]), 0);
        chk("lb_t5_ypos", 32'(yp[2]), 96);
        chk("lb_t5_anim", 32'(an[2]), 1);

        // u3: landing clamps ypos, then absorbing
        pulse(3);
        chk("land_ypos", 32'(yp[3]), 736);
        chk("land_flag", 32'(ld[3]), 1);
        chk("land_anim", 32'(an[3]), 1);
        chk("land_strobe", 32'(s_at2[3]), 1);
        snap = sc[3];
        for (int k = 0; k < 10; k++) pulse(3);
        chk("landed_strobes", 32'(sc[3] - snap), 0);
        chk("landed_xpos", 32'(xp[3]), 992);
        chk("landed_ypos", 32'(yp[3]), 736);
        chk("landed_anim", 32'(an[3]), 1);
        rs[3] = 1'b1;
        @(negedge clk);
        rs[3] = 1'b0;
        chk("land_restart_flag", 32'(ld[3]), 0);
        chk("land_restart_ypos", 32'(yp[3]), 720);

        // asynchronous reset mid-cycle, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_xpos0", 32'(xp[0]), 64);
        chk("async_anim0", 32'(an[0]), 0);
        chk("async_xpos1", 32'(xp[1]), 976);
        chk("async_ypos2", 32'(yp[2]), 64);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
